// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch stage with credit-limited memory requests and output FIFO
//
// Purpose: issues instruction-memory requests at the current PC, tags each
// accepted request with its address, and buffers returned words for decode.
// A redirect (Flush) empties the buffers and discards responses still in flight.
// A misaligned PC halts fetch until the next redirect.
//
// Ports:
//   Clk_Core, Rst_Core           clock, synchronous active-high reset
//   Program_Count, PC_Advance    PC from the PC stage / advance pulse back to it
//   Flush                        redirect; Program_Count carries the target
//   Imem_Req_*                   request channel (valid/ready, address)
//   Imem_Rsp_*                   in-order response channel (valid, data)
//   Inst_*                       decode channel (valid/ready, data, PC)
//   Fetch_Fault                  high while halted on a misaligned fetch
module instruction_fetch #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 2
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic [DWIDTH-1:0] Program_Count,
  output logic              PC_Advance,
  input  logic              Flush,
  output logic              Imem_Req_Valid,
  input  logic              Imem_Req_Ready,
  output logic [DWIDTH-1:0] Imem_Req_Addr,
  input  logic              Imem_Rsp_Valid,
  input  logic [DWIDTH-1:0] Imem_Rsp_Data,
  output logic              Inst_Valid,
  input  logic              Inst_Ready,
  output logic [DWIDTH-1:0] Inst_Data,
  output logic [DWIDTH-1:0] Inst_PC,
  output logic              Fetch_Fault
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic [CW-1:0]     disc_cnt_q, disc_cnt_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [DWIDTH-1:0] tag_mem_q [DEPTH];
  logic [PW-1:0]     tag_wr_q, tag_rd_q;
  logic [DWIDTH-1:0] fifo_pc_q [DEPTH];
  logic [DWIDTH-1:0] fifo_data_q [DEPTH];
  logic [PW-1:0]     fifo_wr_q, fifo_rd_q;

  logic          misaligned, room, req_valid, req_fire;
  logic          rsp_fire, rsp_keep, inst_valid, fifo_pop;
  logic [CW:0]   credit_sum;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    misaligned = Program_Count[1:0] != 2'b00;
    inst_valid = (fifo_cnt_q != '0) && !Flush && !Rst_Core;
    fifo_pop   = inst_valid && Inst_Ready;
    // A word leaving the FIFO this cycle frees its slot for a new request,
    // which keeps back-to-back streaming at one instruction per cycle.
    credit_sum = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q} - {{CW{1'b0}}, fifo_pop};
    room       = credit_sum < (CW + 1)'(DEPTH);
    req_valid  = (state_q == S_RUN) && !Flush && !misaligned && room && !Rst_Core;
    req_fire   = req_valid && Imem_Req_Ready;
    // Responses with nothing outstanding (e.g. just after reset) are ignored.
    rsp_fire   = Imem_Rsp_Valid && (out_cnt_q != '0);
    rsp_keep   = rsp_fire && !Flush && (disc_cnt_q == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (!Flush && misaligned && room) state_d = S_HALT;
      S_HALT:  if (Flush) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(rsp_fire);
    disc_cnt_d = disc_cnt_q;
    fifo_cnt_d = fifo_cnt_q + CW'(rsp_keep) - CW'(fifo_pop);
    if (Flush) begin
      // Everything still in flight becomes a discard, except a response
      // that is being dropped right now.
      disc_cnt_d = out_cnt_q - CW'(rsp_fire);
      fifo_cnt_d = '0;
    end else if (rsp_fire && (disc_cnt_q != '0)) begin
      disc_cnt_d = disc_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state_q    <= S_IDLE;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
      fifo_cnt_q <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_q[i]   <= '0;
        fifo_pc_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (Flush) begin
        tag_wr_q  <= '0;
        tag_rd_q  <= '0;
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
      end else begin
        if (req_fire) begin
          tag_mem_q[tag_wr_q] <= Program_Count;
          tag_wr_q            <= ptr_inc(tag_wr_q);
        end
        if (rsp_keep) begin
          tag_rd_q               <= ptr_inc(tag_rd_q);
          fifo_pc_q[fifo_wr_q]   <= tag_mem_q[tag_rd_q];
          fifo_data_q[fifo_wr_q] <= Imem_Rsp_Data;
          fifo_wr_q              <= ptr_inc(fifo_wr_q);
        end
        if (fifo_pop) begin
          fifo_rd_q <= ptr_inc(fifo_rd_q);
        end
      end
    end
  end

  assign Imem_Req_Valid = req_valid;
  assign Imem_Req_Addr  = Program_Count;
  assign PC_Advance     = req_fire;
  assign Inst_Valid     = inst_valid;
  assign Inst_Data      = Rst_Core ? '0 : fifo_data_q[fifo_rd_q];
  assign Inst_PC        = Rst_Core ? '0 : fifo_pc_q[fifo_rd_q];
  assign Fetch_Fault    = (state_q == S_HALT) && !Rst_Core;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter DWIDTH, default 32, data and address width.
REQ-002 Parameter DEPTH, default 2, maximum in-flight plus buffered fetches.
REQ-003 Clk_Core  input  1  core clock; all state updates on the rising edge.
REQ-004 Rst_Core  input  1  reset; synchronous, active-high.
REQ-005 Program_Count  input  DWIDTH  current PC from the program counter stage.
REQ-006 PC_Advance  output  1  pulse; the PC stage loads its next value this cycle.
REQ-007 Flush  input  1  redirect (taken branch/jump); Program_Count holds the target this cycle.
REQ-008 Imem_Req_Valid  output  1  instruction memory request valid.
REQ-009 Imem_Req_Ready  input  1  memory accepts the request.
REQ-010 Imem_Req_Addr  output  DWIDTH  request address.
REQ-011 Imem_Rsp_Valid  input  1  response valid; in order, minimum 1 cycle after acceptance.
REQ-012 Imem_Rsp_Data  input  DWIDTH  response instruction word.
REQ-013 Inst_Valid  output  1  instruction available to decode.
REQ-014 Inst_Ready  input  1  decode accepts the instruction.
REQ-015 Inst_Data  output  DWIDTH  instruction word.
REQ-016 Inst_PC  output  DWIDTH  address of Inst_Data.
REQ-017 Fetch_Fault  output  1  level; misaligned fetch detected, fetch halted.

Function
REQ-018 FSM states IDLE, RUN, HALT.
- IDLE -> RUN unconditionally after one cycle.
- RUN -> HALT when Program_Count[1:0] != 0 while a request would issue.
- HALT -> RUN on Flush.
REQ-019 Imem_Req_Valid = (state RUN) and not Flush and Program_Count[1:0]==0 and (outstanding + buffered) < DEPTH.
REQ-020 Imem_Req_Addr equals Program_Count combinationally.
REQ-021 PC_Advance equals Imem_Req_Valid and Imem_Req_Ready, so the PC moves exactly once per accepted request.
REQ-022 Each accepted request pushes its address into an in-order PC tag queue (DEPTH entries).
REQ-023 Each non-discarded response pops the tag queue and writes {tag, data} into a DEPTH-entry output FIFO in the same edge.
REQ-024 Inst_Valid is high whenever the output FIFO is non-empty and Flush is low; Inst_Data and Inst_PC show the FIFO head.
- Data path is registered; no combinational path from Imem_Rsp_* to Inst_*.
- Minimum latency is 1 cycle from response to Inst_Valid.
REQ-025 An Inst_Valid and Inst_Ready handshake pops the head.
- Simultaneous push and pop on a full FIFO is legal.
- Inst_* hold stable while Inst_Valid is high and Inst_Ready is low.
REQ-026 Flush clears the output FIFO and the tag queue in one edge.
- Loads the discard counter with the number of outstanding requests, minus one if a response arrives in that same cycle.
REQ-027 While the discard counter is non-zero, each response decrements it and is dropped with no FIFO write.
- Discarded responses do not block new requests; they count as outstanding until returned.
REQ-028 During a Flush cycle: no request issues, no output handshake occurs, and an arriving response is dropped.
REQ-029 Counters are $clog2(DEPTH+1) bits wide.
- Outstanding + buffered never exceeds DEPTH.
- No counter wraps.
- A response with zero outstanding is ignored.
REQ-030 Fetch_Fault is high exactly while in HALT. In HALT:
- No requests issue.
- Outstanding responses still drain to the FIFO, or are discarded per the counter.

Reset
REQ-031 While Rst_Core is high, on each edge:
- State goes to IDLE.
- FIFO, tag queue, outstanding counter and discard counter go to 0.
REQ-032 While Rst_Core is high, outputs read: Imem_Req_Valid 0, PC_Advance 0, Inst_Valid 0, Inst_Data 0, Inst_PC 0, Fetch_Fault 0.
REQ-033 Reset asserted mid-operation abandons all in-flight requests; responses arriving in the cycle after reset release are ignored.

Verification
REQ-034 Streaming: after reset, PC 0x0,0x4,0x8 with Imem_Req_Ready=1, 1-cycle response, Inst_Ready=1 -> Inst_PC 0x0,0x4,0x8 on consecutive cycles, one PC_Advance per request.
REQ-035 Backpressure: Inst_Ready=0 with DEPTH=2 -> exactly 2 requests issue, then Imem_Req_Valid=0 and PC_Advance=0; Inst_PC/Inst_Data stable. Release Inst_Ready -> fetch resumes at the third PC.
REQ-036 Flush with 2 outstanding at 3-cycle latency, target 0x100 -> both old responses dropped, first Inst_PC=0x100, no stale instruction visible.
REQ-037 Misaligned: Program_Count=0x102 -> no request, Fetch_Fault=1, state HALT. Flush with target 0x200 -> Fetch_Fault=0 and a request issues at 0x200.
REQ-038 Simultaneous events: response and Flush in the same cycle, and FIFO-full push+pop -> no loss, no duplication, counters stay at or below DEPTH.
REQ-039 Reset mid-stream with 2 outstanding -> all outputs 0 the cycle after; a late response produces no Inst_Valid.
